// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch path.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE,
    DONE
  } fetch_state_t;

  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned LINE_W   = 10;

endpackage

// File: rtl/sprite_row_hit.sv
// Combinational test of whether a sprite covers a scanline, plus the row
// within the sprite that the scanline lands on.
module sprite_row_hit
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_H = 16,
  parameter int unsigned ROW_W = $clog2(SPR_H)
) (
  input  logic              en,
  input  logic [LINE_W-1:0] line,
  input  logic [LINE_W-1:0] y,
  output logic              hit,
  output logic [ROW_W-1:0]  row
);

  logic [LINE_W:0] line_x;
  logic [LINE_W:0] y_x;
  logic [LINE_W:0] y_end;
  logic [LINE_W:0] diff;

  // One extra bit so a sprite starting near the bottom of the line range
  // never wraps back onto the top scanlines.
  always_comb begin
    line_x = {1'b0, line};
    y_x    = {1'b0, y};
    y_end  = y_x + (LINE_W + 1)'(SPR_H);
    diff   = line_x - y_x;
    hit    = en && (line_x >= y_x) && (line_x < y_end);
    row    = diff[ROW_W-1:0];
  end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Walks the sprite slots during hblank, and for every slot covering the next
// scanline streams that sprite row out of the shared ROM into the line buffer.
module sprite_fetch_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned PIX_W     = 2,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS),
  localparam int unsigned COL_W    = $clog2(SPR_W),
  localparam int unsigned ROW_W    = $clog2(SPR_H)
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          hblank_start,
  input  logic [LINE_W-1:0]             next_line,
  input  logic [NUM_SLOTS-1:0]          slot_en,
  input  logic [NUM_SLOTS*LINE_W-1:0]   slot_y,
  input  logic [NUM_SLOTS*ADDR_W-1:0]   slot_base,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [PIX_W-1:0]              rom_q,
  output logic                          lb_we,
  output logic [SLOT_W-1:0]             lb_slot,
  output logic [COL_W-1:0]              lb_col,
  output logic [PIX_W-1:0]              lb_data,
  output logic [NUM_SLOTS-1:0]          row_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  fetch_state_t                  state;
  logic [SLOT_W-1:0]             slot_q;
  logic [COL_W-1:0]              col_q;
  logic [LINE_W-1:0]             line_q;
  logic [NUM_SLOTS-1:0]          en_q;
  logic [NUM_SLOTS*LINE_W-1:0]   y_q;
  logic [NUM_SLOTS*ADDR_W-1:0]   base_q;

  logic                          en_sel;
  logic [LINE_W-1:0]             y_sel;
  logic [ADDR_W-1:0]             base_sel;
  logic                          hit;
  logic [ROW_W-1:0]              row;
  logic [ADDR_W-1:0]             row_base;
  logic                          last_slot;

  // Select the snapshot fields of the slot currently being scanned/fetched.
  always_comb begin
    en_sel    = en_q[slot_q];
    y_sel     = y_q[int'(slot_q) * LINE_W +: LINE_W];
    base_sel  = base_q[int'(slot_q) * ADDR_W +: ADDR_W];
    row_base  = base_sel + ADDR_W'(row) * ADDR_W'(SPR_W);
    last_slot = (slot_q == SLOT_W'(NUM_SLOTS - 1));
  end

  sprite_row_hit #(
    .SPR_H (SPR_H),
    .ROW_W (ROW_W)
  ) u_row_hit (
    .en   (en_sel),
    .line (line_q),
    .y    (y_sel),
    .hit  (hit),
    .row  (row)
  );

  // ROM data arrives one clock after the address, in step with lb_we.
  always_comb begin
    lb_data = lb_we ? rom_q : '0;
  end

  // Fetch FSM, slot/column counters and the one-stage read pipeline.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= IDLE;
      slot_q    <= '0;
      col_q     <= '0;
      line_q    <= '0;
      en_q      <= '0;
      y_q       <= '0;
      base_q    <= '0;
      rom_addr  <= '0;
      lb_we     <= 1'b0;
      lb_slot   <= '0;
      lb_col    <= '0;
      row_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done    <= 1'b0;
      lb_we   <= 1'b0;
      overrun <= hblank_start && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (hblank_start) begin
            line_q <= next_line;
            en_q   <= slot_en;
            y_q    <= slot_y;
            base_q <= slot_base;
            slot_q <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          row_valid[slot_q] <= hit;
          if (hit) begin
            col_q    <= '0;
            rom_addr <= row_base;
            state    <= ISSUE;
          end else if (last_slot) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        ISSUE: begin
          lb_we   <= 1'b1;
          lb_slot <= slot_q;
          lb_col  <= col_q;
          if (col_q == COL_W'(SPR_W - 1)) begin
            if (last_slot) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              slot_q <= slot_q + 1'b1;
              state  <= SCAN;
            end
          end else begin
            col_q    <= col_q + 1'b1;
            rom_addr <= row_base + ADDR_W'(col_q) + ADDR_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed and randomized bench for sprite_fetch_scheduler with a
// schedule-level reference model and a synchronous ROM model.
module tb_sprite_fetch_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        hblank_start;
  logic [9:0]  next_line;
  logic [3:0]  slot_en;
  logic [39:0] slot_y;
  logic [47:0] slot_base;
  logic [11:0] rom_addr;
  logic [1:0]  rom_q;
  logic        lb_we;
  logic [1:0]  lb_slot;
  logic [3:0]  lb_col;
  logic [1:0]  lb_data;
  logic [3:0]  row_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Test configuration (the snapshot the DUT should take).
  int cfg_line;
  int cfg_en   [4];
  int cfg_y    [4];
  int cfg_base [4];

  // Reference schedule indexed by cycle after the pulse (pulse in cycle 0).
  bit         exp_we   [0:159];
  int         exp_slot [0:159];
  int         exp_col  [0:159];
  int         exp_addr [0:159];
  int         exp_done;
  logic [3:0] exp_rv;
  logic [3:0] prev_rv;

  sprite_fetch_scheduler dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .hblank_start (hblank_start),
    .next_line    (next_line),
    .slot_en      (slot_en),
    .slot_y       (slot_y),
    .slot_base    (slot_base),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .lb_we        (lb_we),
    .lb_slot      (lb_slot),
    .lb_col       (lb_col),
    .lb_data      (lb_data),
    .row_valid    (row_valid),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [1:0] rom_fn(input logic [11:0] a);
    return a[1:0] ^ a[3:2] ^ a[5:4] ^ a[9:8] ^ {a[11], a[6]};
  endfunction

  always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input int en, input int y, input int base);
    cfg_en[s]   = en;
    cfg_y[s]    = y;
    cfg_base[s] = base;
  endtask

  // Slots are visited in order: one scan cycle each, plus SPR_W issue cycles
  // for a hit; each issue is written to the line buffer one cycle later.
  task automatic build_model();
    int cur;
    for (int i = 0; i < 160; i++) begin
      exp_we[i] = 1'b0; exp_slot[i] = 0; exp_col[i] = 0; exp_addr[i] = 0;
    end
    exp_rv = '0;
    cur = 1;
    for (int s = 0; s < 4; s++) begin
      bit h;
      h = (cfg_en[s] != 0) && (cfg_line >= cfg_y[s]) && (cfg_line < cfg_y[s] + 16);
      exp_rv[s] = h;
      cur++;
      if (h) begin
        for (int c = 0; c < 16; c++) begin
          exp_we[cur+1]   = 1'b1;
          exp_slot[cur+1] = s;
          exp_col[cur+1]  = c;
          exp_addr[cur+1] = (cfg_base[s] + (cfg_line - cfg_y[s]) * 16 + c) % 4096;
          cur++;
        end
      end
    end
    exp_done = cur;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_lb_we"}, 32'(lb_we), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_row_valid"}, 32'(row_valid), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_lb"}, 32'({lb_slot, lb_col, lb_data}), 32'd0);
  endtask

  // ov_at: cycle in which a second pulse is driven (0 none, -1 the DONE cycle).
  // rst_at: cycle in which reset is raised (0 none).
  task automatic run_fetch(input int ov_at, input int rst_at);
    logic [11:0] addr_hist [0:160];
    int ov;
    build_model();
    ov = (ov_at < 0) ? exp_done : ov_at;
    @(posedge vga_clk); #1;
    check("row_valid_hold", 32'(row_valid), 32'(prev_rv));
    check("idle_busy", 32'(busy), 32'd0);
    next_line = 10'(cfg_line);
    for (int s = 0; s < 4; s++) begin
      slot_en[s]           = cfg_en[s][0];
      slot_y[s*10 +: 10]   = 10'(cfg_y[s]);
      slot_base[s*12 +: 12] = 12'(cfg_base[s]);
    end
    hblank_start = 1'b1;
    addr_hist[0] = rom_addr;
    for (int n = 1; n <= exp_done + 2; n++) begin
      @(posedge vga_clk); #1;
      addr_hist[n] = rom_addr;
      if (rst_at != 0 && n == rst_at + 1) begin
        check_all_zero("after_reset");
        reset = 1'b0;
        @(posedge vga_clk); #1;
        check("post_reset_lb_we", 32'(lb_we), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        prev_rv = '0;
        return;
      end
      check("busy", 32'(busy), 32'(n <= exp_done));
      check("done", 32'(done), 32'(n == exp_done));
      check("lb_we", 32'(lb_we), 32'(exp_we[n]));
      if (exp_we[n]) begin
        check("lb_slot", 32'(lb_slot), 32'(exp_slot[n]));
        check("lb_col", 32'(lb_col), 32'(exp_col[n]));
        check("lb_data", 32'(lb_data), 32'(rom_fn(12'(exp_addr[n]))));
        check("rom_addr", 32'(addr_hist[n-1]), 32'(exp_addr[n]));
      end
      check("overrun", 32'(overrun), 32'(ov != 0 && n == ov + 1));
      if (n == exp_done) check("row_valid", 32'(row_valid), 32'(exp_rv));
      // Drive for the next cycle; mid-fetch input changes must be ignored.
      if (n == 1) begin
        hblank_start = 1'b0;
        next_line    = 10'($urandom);
        slot_en      = 4'($urandom);
        slot_y       = {8'($urandom), $urandom};
        slot_base    = {16'($urandom), $urandom};
      end
      if (ov != 0 && n == ov) hblank_start = 1'b1;
      if (ov != 0 && n == ov + 1) hblank_start = 1'b0;
      if (rst_at != 0 && n == rst_at) reset = 1'b1;
    end
    hblank_start = 1'b0;
    prev_rv = exp_rv;
  endtask

  task automatic clear_cfg();
    for (int s = 0; s < 4; s++) set_slot(s, 0, 0, 0);
  endtask

  initial begin
    reset        = 1'b1;
    hblank_start = 1'b0;
    next_line    = '0;
    slot_en      = '0;
    slot_y       = '0;
    slot_base    = '0;
    prev_rv      = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // No slots enabled: scan only, done five cycles after the pulse.
    clear_cfg();
    cfg_line = 200;
    run_fetch(0, 0);

    // Single hit on slot 1, row 3.
    clear_cfg();
    cfg_line = 103;
    set_slot(1, 1, 100, 'h200);
    run_fetch(0, 0);

    // All four slots hit.
    cfg_line = 103;
    set_slot(0, 1, 90, 'h000);
    set_slot(1, 1, 95, 'h3F0);
    set_slot(2, 1, 100, 'h800);
    set_slot(3, 1, 103, 'hFF8);
    run_fetch(0, 0);

    // Row boundaries and no wrap near the bottom of the line range.
    clear_cfg();
    set_slot(0, 1, 100, 'h100);
    cfg_line = 115; run_fetch(0, 0);
    cfg_line = 116; run_fetch(0, 0);
    cfg_line = 99;  run_fetch(0, 0);
    set_slot(0, 1, 1020, 'h100);
    cfg_line = 5;    run_fetch(0, 0);
    cfg_line = 1023; run_fetch(0, 0);

    // Second pulse mid-fetch, and one in the DONE cycle.
    clear_cfg();
    cfg_line = 103;
    set_slot(0, 1, 100, 'h040);
    set_slot(2, 1, 95, 'hA00);
    run_fetch(10, 0);
    run_fetch(-1, 0);

    // Reset mid-issue, then a full fetch afterwards.
    cfg_line = 103;
    set_slot(0, 1, 90, 'h000);
    set_slot(1, 1, 95, 'h3F0);
    set_slot(2, 1, 100, 'h800);
    set_slot(3, 1, 103, 'hFF8);
    run_fetch(0, 8);
    run_fetch(0, 0);

    // Randomized slot sets around the target line.
    for (int k = 0; k < 10; k++) begin
      cfg_line = int'($urandom_range(0, 1023));
      for (int s = 0; s < 4; s++) begin
        set_slot(s, int'($urandom_range(0, 1)),
                 (cfg_line - int'($urandom_range(0, 20)) + 1024) % 1024,
                 int'($urandom_range(0, 4095)));
      end
      run_fetch(0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
